// File: rtl/mbi5124_pkg.sv
// mbi5124_pkg: shared constants and the one-hot decode used by the MBI5124 receiver and transmitter.
package mbi5124_pkg;
  localparam int N_BITS_DEF = 16;
  localparam int VALUE_W_DEF = 5;
  localparam logic [VALUE_W_DEF-1:0] VALUE_INVALID = '1;
  // Returns 0 for an empty pattern, k+1 for a single bit k, -1 when more than one bit is set.
  function automatic int onehot_to_value(input logic [31:0] pat);
    int v;
    v = 0;
    for (int i = 0; i < 32; i++)
      if (pat[i]) v = (v == 0) ? i + 1 : -1;
    return v;
  endfunction
endpackage

// File: rtl/mbi5124_rx_sync_edge.sv
// sync_edge: multi-stage input synchronizer with optional rising-edge detect and configurable reset level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0,
  parameter logic EDGE    = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);
  localparam int W = STAGES + (EDGE ? 1 : 0);
  logic [W-1:0] sr_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sr_q <= {W{RST_VAL}};
    else sr_q <= {sr_q[W-2:0], d_i};
  if (EDGE) begin : g_rise
    assign q_o = sr_q[W-2] & ~sr_q[W-1];
  end else begin : g_lvl
    assign q_o = sr_q[W-1];
  end
endmodule

// File: rtl/mbi5124_rx.sv
// mbi5124_rx: oversampling receiver for the MBI5124 serial LED interface with latch, oe gating and one-hot decode.
module mbi5124_rx
  import mbi5124_pkg::*;
#(
  parameter int N_BITS      = N_BITS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int VALUE_W     = VALUE_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sdi,
  input  logic               led_clk,
  input  logic               le,
  input  logic               oe,
  output logic               sdo,
  output logic [N_BITS-1:0]  leds_latched,
  output logic [N_BITS-1:0]  leds_out,
  output logic [VALUE_W-1:0] value,
  output logic               frame_done,
  output logic               len_err,
  output logic               onehot_err
);
  localparam int CNT_W = $clog2(N_BITS) + 1;
  logic sdi_s, rise_clk, rise_le, oe_s;
  logic [N_BITS-1:0] shift_q, shift_d, latched_q, latched_d, leds_out_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [VALUE_W-1:0] value_q, value_d;
  logic frame_q, len_q, oh_q;
  int idx;
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE(1'b0)) u_sdi (.clk(clk), .rstn(rstn), .d_i(sdi), .q_o(sdi_s));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE(1'b1)) u_clk (.clk(clk), .rstn(rstn), .d_i(led_clk), .q_o(rise_clk));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE(1'b1)) u_le (.clk(clk), .rstn(rstn), .d_i(le), .q_o(rise_le));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE(1'b0)) u_oe (.clk(clk), .rstn(rstn), .d_i(oe), .q_o(oe_s));
  // A shift coinciding with a latch belongs to the frame being latched.
  always_comb begin
    shift_d = rise_clk ? {shift_q[N_BITS-2:0], sdi_s} : shift_q;
    cnt_inc = (rise_clk && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    cnt_d = rise_le ? '0 : cnt_inc;
    latched_d = {<<{shift_d}};
    idx = onehot_to_value(32'(latched_d));
    value_d = (idx < 0) ? '1 : VALUE_W'(idx);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      shift_q <= '0;
      cnt_q <= '0;
      latched_q <= '0;
      leds_out_q <= '0;
      value_q <= '0;
      frame_q <= 1'b0;
      len_q <= 1'b0;
      oh_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      frame_q <= rise_le;
      leds_out_q <= oe_s ? '0 : latched_q;
      if (rise_le) begin
        latched_q <= latched_d;
        value_q <= value_d;
        len_q <= cnt_inc != CNT_W'(N_BITS);
        oh_q <= idx < 0;
      end
    end
  assign sdo = shift_q[N_BITS-1];
  assign leds_latched = latched_q;
  assign leds_out = leds_out_q;
  assign value = value_q;
  assign frame_done = frame_q;
  assign len_err = len_q;
  assign onehot_err = oh_q;
endmodule

// File: tb/tb_mbi5124_rx.sv
// tb_mbi5124_rx: directed frames with a scoreboard queue checked by a frame_done-driven monitor.
module tb_mbi5124_rx;
  typedef struct {
    logic [15:0] ll;
    logic [4:0]  v;
    logic        le;
    logic        oh;
    logic [15:0] lo;
  } exp_t;
  logic clk = 0, rstn = 0, sdi = 0, led_clk = 0, le = 0, oe = 0;
  logic sdo, frame_done, len_err, onehot_err;
  logic [15:0] leds_latched, leds_out;
  logic [4:0] value;
  exp_t q[$];
  int errors = 0, checks = 0, nfr = 0;
  mbi5124_rx dut (
    .clk(clk), .rstn(rstn), .sdi(sdi), .led_clk(led_clk), .le(le), .oe(oe),
    .sdo(sdo), .leds_latched(leds_latched), .leds_out(leds_out), .value(value),
    .frame_done(frame_done), .len_err(len_err), .onehot_err(onehot_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    sdi = b;
    cyc(2);
    led_clk = 1;
    cyc(2);
    led_clk = 0;
  endtask
  task automatic latch();
    le = 1;
    cyc(2);
    le = 0;
    cyc(4);
  endtask
  task automatic frame(input logic [15:0] pat, input int nb, input exp_t e);
    for (int i = 0; i < nb; i++) send_bit(pat[i]);
    q.push_back(e);
    latch();
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got frame_done with empty scoreboard");
        end else begin
          e = q.pop_front();
          nfr++;
          chk("leds_latched", 32'(leds_latched), 32'(e.ll));
          chk("value", 32'(value), 32'(e.v));
          chk("len_err", 32'(len_err), 32'(e.le));
          chk("onehot_err", 32'(onehot_err), 32'(e.oh));
          @(negedge clk);
          chk("leds_out", 32'(leds_out), 32'(e.lo));
          chk("frame_done_width", 32'(frame_done), 32'(0));
        end
      end
    end
  end
  initial begin
    cyc(3);
    chk("rst_leds_latched", 32'(leds_latched), 0);
    chk("rst_leds_out", 32'(leds_out), 0);
    chk("rst_value", 32'(value), 0);
    chk("rst_flags", {29'd0, frame_done, len_err, onehot_err}, 0);
    chk("rst_sdo", 32'(sdo), 0);
    rstn = 1;
    cyc(3);
    frame(16'h0010, 16, '{16'h0010, 5'd5, 1'b0, 1'b0, 16'h0010});
    frame(16'h8000, 16, '{16'h8000, 5'd16, 1'b0, 1'b0, 16'h8000});
    frame(16'h0000, 16, '{16'h0000, 5'd0, 1'b0, 1'b0, 16'h0000});
    frame(16'h0001, 10, '{16'h0040, 5'd7, 1'b1, 1'b0, 16'h0040});
    frame(16'h0002, 16, '{16'h0002, 5'd2, 1'b0, 1'b0, 16'h0002});
    oe = 1;
    frame(16'h0005, 16, '{16'h0005, 5'd31, 1'b0, 1'b1, 16'h0000});
    oe = 0;
    cyc(5);
    chk("oe_reenable", 32'(leds_out), 32'h0005);
    for (int i = 0; i < 15; i++) send_bit(1'b0);
    q.push_back('{16'h8000, 5'd16, 1'b0, 1'b0, 16'h8000});
    sdi = 1;
    cyc(2);
    led_clk = 1;
    le = 1;
    cyc(2);
    led_clk = 0;
    le = 0;
    cyc(4);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    rstn = 0;
    cyc(2);
    chk("midrst_leds_latched", 32'(leds_latched), 0);
    chk("midrst_leds_out", 32'(leds_out), 0);
    chk("midrst_value", 32'(value), 0);
    chk("midrst_flags", {29'd0, frame_done, len_err, onehot_err}, 0);
    rstn = 1;
    cyc(3);
    frame(16'h0004, 16, '{16'h0004, 5'd3, 1'b0, 1'b0, 16'h0004});
    for (int i = 0; i < 200 && q.size() > 0; i++) cyc(1);
    cyc(3);
    chk("scoreboard_drained", 32'(q.size()), 0);
    chk("frames_seen", 32'(nfr), 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
